// File: rtl/bitstream_decoder.sv
// -----------------------------------------------------------------------------
// bitstream_decoder
//
// Purpose:
//   Turns a stochastic bitstream back into a binary number. It counts the ones
//   over a window of 2^WIDTH enabled cycles and presents each window result on
//   a valid/ready handshake. A result replaced before the consumer took it sets
//   the sticky overrun flag.
//
// Configuration macro:
//   BITSTREAM_DECODER_BIPOLAR_EN
//     undefined : value = ones count, zero-extended, range 0..N
//     defined   : value = ones count - N/2, two's complement, range -N/2..+N/2
//
// Parameters:
//   WIDTH   log2 of the window length N (WIDTH >= 2)
//
// Ports:
//   clk      in   1        clock, rising edge
//   n_rst    in   1        synchronous active-low reset
//   clr      in   1        synchronous soft clear (value register keeps contents)
//   en       in   1        sample enable; x is counted only when en=1
//   x        in   1        stochastic input bit
//   value    out  WIDTH+1  decoded window result
//   valid    out  1        value holds an unconsumed result
//   ready    in   1        consumer accepts value this cycle
//   overrun  out  1        sticky: a result was overwritten before consumption
// -----------------------------------------------------------------------------
module bitstream_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
    output logic [WIDTH:0]   value,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    // Half the window length, used as the bipolar offset.
    localparam logic [WIDTH:0] HALF_N = (WIDTH+1)'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] r_wcnt;
    logic [WIDTH:0]   r_ocnt;
    logic [WIDTH:0]   r_value;
    logic             r_valid;
    logic             r_overrun;

    logic             w_win_end;
    logic             w_xfer;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_result;

    // Convert a raw ones count into the output number format.
    function automatic logic [WIDTH:0] f_encode(input logic [WIDTH:0] cnt);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
        return cnt - HALF_N;
`else
        return cnt;
`endif
    endfunction

    // The window ends on the enabled cycle where wcnt sits at N-1 (all ones).
    assign w_win_end = en && (&r_wcnt);
    assign w_xfer    = r_valid && ready;
    // ocnt never exceeds N, so WIDTH+1 bits hold ocnt+x without wrap.
    assign w_sum     = r_ocnt + (WIDTH+1)'(x);
    assign w_result  = f_encode(w_sum);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wcnt    <= '0;
            r_ocnt    <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            // Partial window discarded; the last result stays readable.
            r_wcnt    <= '0;
            r_ocnt    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_win_end) begin
                r_wcnt  <= '0;
                r_ocnt  <= '0;
                r_value <= w_result;
                r_valid <= 1'b1;
                // Replacing a result nobody accepted loses it.
                if (r_valid && !ready) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                if (en) begin
                    r_wcnt <= r_wcnt + 1'b1;
                    r_ocnt <= w_sum;
                end
                if (w_xfer) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign value   = r_value;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule
